instr_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read port. It owns the PC and drives imem_addr_o.
//  It samples the combinational instr_i return and buffers {pc, instr} pairs in a 2-entry FIFO.
//  The FIFO feeds decode over a valid/ready handshake.

---
 rtl/if_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

    localparam int unsigned FETCH_FIFO_DEPTH = 2;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetch entries; flush has priority over push.
// When empty, rdata keeps presenting the most recently exposed head entry.
module fetch_fifo
    import if_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem_q [FETCH_FIFO_DEPTH];
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic [1:0]   cnt_q, cnt_d;

    assign full  = (cnt_q == 2'(FETCH_FIFO_DEPTH));
    assign empty = (cnt_q == 2'd0);

    // The slot behind rd_q holds the entry last shown at the head.
    assign rdata = empty ? mem_q[~rd_q] : mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
            // Step both pointers past the current head so it stays visible while empty.
            if (cnt_q != 2'd0) begin
                rd_d = ~rd_q;
                wr_d = ~rd_q;
            end
        end else begin
            if (push) wr_d = ~wr_q;
            if (pop)  rd_d = ~rd_q;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
            for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push && !flush) begin
                mem_q[wr_q] <= wdata;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, reads instruction memory and buffers {pc, instr, err} for decode.
// Optional fetch error reporting is enabled by defining FETCH_ERR_CHECK_EN.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned IMEM_W   = 13,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [IMEM_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_instr_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_pc_o,
    output logic [31:0]       out_instr_o,
    output logic              out_err_o
);

    logic [31:0]  pc_q, pc_d;
    logic         push, pop;
    logic         full, empty;
    logic         fetch_err;
    fetch_entry_t wr_entry, head;

    assign imem_addr_o = pc_q[IMEM_W-1:0];
    assign out_valid_o = !empty;
    assign pop         = out_valid_o && out_ready_i;
    assign push        = !redirect_valid_i && (!full || pop);

    assign wr_entry = '{pc: pc_q, instr: imem_instr_i, err: fetch_err};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo u_fetch_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .flush  (redirect_valid_i),
        .wdata  (wr_entry),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

    assign out_pc_o    = head.pc;
    assign out_instr_o = head.instr;

`ifdef FETCH_ERR_CHECK_EN
    logic misalign_q, misalign_d;

    // A misaligned redirect is remembered until the first entry fetched from its target.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid_i) begin
            misalign_d = (redirect_pc_i[1:0] != 2'b00);
        end else if (push) begin
            misalign_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_err = misalign_q || (pc_q[31:IMEM_W] != '0);
    assign out_err_o = head.err;
`else
    logic unused_err_bits;

    assign fetch_err       = 1'b0;
    assign out_err_o       = 1'b0;
    assign unused_err_bits = ^{head.err, redirect_pc_i[1:0]};
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: per-cycle vector table plus a stream scoreboard.
module tb_instr_fetch_unit;

    localparam int unsigned IMEM_W = 13;
    localparam int          NV     = 32;
    localparam int          SB_LEN = 8;
`ifdef FETCH_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic              rst;
        logic              rdy;
        logic              redir;
        logic [31:0]       rpc;
        logic              exp_valid;
        logic [31:0]       exp_pc;
        logic [IMEM_W-1:0] exp_addr;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [IMEM_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic              out_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [NV];
    exp_t sb_q [$];

    always #5 clk_i = ~clk_i;

    // Memory word k holds 32'h1000_0000 + k.
    assign imem_instr = 32'h1000_0000 + ({19'b0, imem_addr} >> 2);

    instr_fetch_unit #(
        .IMEM_W   (IMEM_W),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .imem_addr_o      (imem_addr),
        .imem_instr_i     (imem_instr),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pc_o         (out_pc),
        .out_instr_o      (out_instr),
        .out_err_o        (out_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Expected stream after a reset or redirect to start (misaligned flags the first entry).
    task automatic sb_load(input logic [31:0] start, input bit mis);
        logic [31:0] pc;
        exp_t        e;
        sb_q.delete();
        for (int k = 0; k < SB_LEN; k++) begin
            pc      = start + 32'(4 * k);
            e.pc    = pc;
            e.instr = 32'h1000_0000 + ((pc & 32'h1FFF) >> 2);
            e.err   = ERR_EN && ((mis && k == 0) || (pc[31:IMEM_W] != '0));
            sb_q.push_back(e);
        end
    endtask

    function automatic vec_t row(input bit rst, input bit rdy, input bit redir,
                                 input logic [31:0] rpc, input bit v,
                                 input logic [31:0] pc, input logic [IMEM_W-1:0] addr);
        vec_t r;
        r = '{rst, rdy, redir, rpc, v, pc, addr};
        return r;
    endfunction

    // Consumer side: every accepted head is checked against the scoreboard.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && !redirect_valid && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow at %0t: got pc %h, expected no output", $time, out_pc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
                chk("sb_err", {31'b0, out_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        // rst rdy redir rpc  valid pc  addr
        vecs[0]  = row(1, 1, 0, 32'h0,    0, 32'h0,    13'h0);
        vecs[1]  = row(0, 1, 0, 32'h0,    0, 32'h0,    13'h0);
        vecs[2]  = row(0, 1, 0, 32'h0,    1, 32'h0,    13'h4);
        vecs[3]  = row(0, 1, 0, 32'h0,    1, 32'h4,    13'h8);
        vecs[4]  = row(0, 1, 0, 32'h0,    1, 32'h8,    13'hC);
        vecs[5]  = row(1, 0, 0, 32'h0,    0, 32'h0,    13'h0);
        vecs[6]  = row(0, 0, 0, 32'h0,    0, 32'h0,    13'h0);
        vecs[7]  = row(0, 0, 0, 32'h0,    1, 32'h0,    13'h4);
        vecs[8]  = row(0, 0, 0, 32'h0,    1, 32'h0,    13'h8);
        vecs[9]  = row(0, 0, 0, 32'h0,    1, 32'h0,    13'h8);
        vecs[10] = row(0, 0, 0, 32'h0,    1, 32'h0,    13'h8);
        vecs[11] = row(0, 1, 0, 32'h0,    1, 32'h0,    13'h8);
        vecs[12] = row(0, 1, 0, 32'h0,    1, 32'h4,    13'hC);
        vecs[13] = row(0, 1, 0, 32'h0,    1, 32'h8,    13'h10);
        vecs[14] = row(0, 1, 1, 32'h100,  1, 32'hC,    13'h14);
        vecs[15] = row(0, 1, 0, 32'h0,    0, 32'hC,    13'h100);
        vecs[16] = row(0, 1, 0, 32'h0,    1, 32'h100,  13'h104);
        vecs[17] = row(0, 1, 1, 32'h40,   1, 32'h104,  13'h108);
        vecs[18] = row(0, 1, 1, 32'h80,   0, 32'h104,  13'h40);
        vecs[19] = row(0, 1, 0, 32'h0,    0, 32'h104,  13'h80);
        vecs[20] = row(0, 1, 0, 32'h0,    1, 32'h80,   13'h84);
        vecs[21] = row(0, 1, 0, 32'h0,    1, 32'h84,   13'h88);
        vecs[22] = row(0, 1, 1, 32'h1FF8, 1, 32'h88,   13'h8C);
        vecs[23] = row(0, 1, 0, 32'h0,    0, 32'h88,   13'h1FF8);
        vecs[24] = row(0, 1, 0, 32'h0,    1, 32'h1FF8, 13'h1FFC);
        vecs[25] = row(0, 1, 0, 32'h0,    1, 32'h1FFC, 13'h0);
        vecs[26] = row(0, 1, 0, 32'h0,    1, 32'h2000, 13'h4);
        vecs[27] = row(0, 1, 0, 32'h0,    1, 32'h2004, 13'h8);
        vecs[28] = row(0, 1, 1, 32'h102,  1, 32'h2008, 13'hC);
        vecs[29] = row(0, 1, 0, 32'h0,    0, 32'h2008, 13'h100);
        vecs[30] = row(0, 1, 0, 32'h0,    1, 32'h100,  13'h104);
        vecs[31] = row(0, 1, 0, 32'h0,    1, 32'h104,  13'h108);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk_i);
            #1;
            rst_ni         = !vecs[i].rst;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            if (vecs[i].rst) begin
                sb_load(32'h0, 1'b0);
            end else if (vecs[i].redir) begin
                sb_load({vecs[i].rpc[31:2], 2'b00}, vecs[i].rpc[1:0] != 2'b00);
            end
            @(negedge clk_i);
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_addr", i), {19'b0, imem_addr}, {19'b0, vecs[i].exp_addr});
        end

        // Mid-stream asynchronous reset: outputs clear without a clock edge.
        @(posedge clk_i);
        #1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk_i);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("pre_rst_pc", out_pc, 32'h108);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_pc", out_pc, 32'h0);
        chk("async_rst_instr", out_instr, 32'h0);
        chk("async_rst_err", {31'b0, out_err}, 32'd0);
        chk("async_rst_addr", {19'b0, imem_addr}, 32'h0);

        // Restart after reset: stream from 0 again.
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        sb_load(32'h0, 1'b0);
        @(negedge clk_i);
        chk("restart_valid0", {31'b0, out_valid}, 32'd0);
        @(negedge clk_i);
        chk("restart_valid1", {31'b0, out_valid}, 32'd1);
        chk("restart_instr1", out_instr, 32'h1000_0000);
        repeat (3) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
